// File: rtl/nv_ram_ctl_60x168.sv
// Purpose : FIFO controller for an external 168-bit RAM with a registered read
//           address and a registered output. An empty-FIFO bypass path is built
//           when NV_RAM_CTL_BYPASS_EN is defined.
// Latency : push at T -> rd_pvld at T+3 through the RAM, or at T+1 on bypass.
// Backpr. : wr_prdy = !full and does not look at rd_prdy. With rd_prdy low, the
//           read pipeline holds rd_pvld/rd_pd and stops issuing RAM reads.
// Ports   : clk/reset        clock, synchronous active-high reset
//           wr_pvld/prdy/pd  push handshake and data
//           rd_pvld/prdy/pd  pop handshake; rd_pd is ram_dout
//           fifo_cnt         occupied entries (0..DEPTH)
//           ram_*            RAM write port, read address port, output-register
//                            enable, bypass select/data, registered read data
// Config  : `define NV_RAM_CTL_BYPASS_EN enables the empty-FIFO bypass path.
module nv_ram_ctl_60x168 #(
  parameter int DEPTH = 60
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [167:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [167:0] rd_pd,
  output logic [5:0]   fifo_cnt,
  output logic [5:0]   ram_wa,
  output logic         ram_we,
  output logic [167:0] ram_di,
  output logic [5:0]   ram_ra,
  output logic         ram_re,
  output logic         ram_ore,
  output logic         ram_byp_sel,
  output logic [167:0] ram_dbyp,
  input  logic [167:0] ram_dout
);

  localparam logic [5:0] DEPTH_C = 6'(DEPTH);
  localparam logic [5:0] LAST_C  = 6'(DEPTH - 1);

  logic [5:0] wp_q, wp_d;
  logic [5:0] rp_q, rp_d;
  // Entries written to the RAM but not yet read-issued.
  logic [5:0] uc_q, uc_d;
  logic [5:0] cnt_q, cnt_d;
  // s1: the RAM address register holds an issued read.
  // s2: the RAM output register holds valid pop data.
  logic       s1_vld_q, s1_vld_d;
  logic       s2_vld_q, s2_vld_d;

  logic push, pop, s2_free, byp, ore_ram;

  always_comb begin
    wr_prdy = !reset && (cnt_q != DEPTH_C);
    rd_pvld = !reset && s2_vld_q;
    push    = wr_pvld && wr_prdy;
    pop     = rd_pvld && rd_prdy;
    // The output register can take new data when empty or being popped.
    s2_free = !s2_vld_q || rd_prdy;
`ifdef NV_RAM_CTL_BYPASS_EN
    // Nothing ahead of this push anywhere in the pipeline: load it straight
    // into the output register.
    byp = push && (uc_q == 6'd0) && !s1_vld_q && s2_free;
`else
    byp = 1'b0;
`endif
    ore_ram     = !reset && s1_vld_q && s2_free;
    ram_ore     = ore_ram || byp;
    ram_byp_sel = byp;
    ram_dbyp    = wr_pd;
    ram_we      = push && !byp;
    ram_wa      = wp_q;
    ram_di      = wr_pd;
    // uc only counts writes from earlier cycles, so a read is never issued
    // to the slot being written this cycle.
    ram_re      = !reset && (uc_q != 6'd0) && (!s1_vld_q || ore_ram);
    ram_ra      = rp_q;
    rd_pd       = ram_dout;
    fifo_cnt    = cnt_q;
  end

  always_comb begin
    wp_d = wp_q;
    if (ram_we) wp_d = (wp_q == LAST_C) ? 6'd0 : wp_q + 6'd1;
    rp_d = rp_q;
    if (ram_re) rp_d = (rp_q == LAST_C) ? 6'd0 : rp_q + 6'd1;
    uc_d = uc_q + {5'd0, ram_we} - {5'd0, ram_re};
    // Entries are freed only at pop, so RAM slots still in the read
    // pipeline stay reserved.
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 6'd1;
    else if (!push && pop) cnt_d = cnt_q - 6'd1;
    s1_vld_d = ram_re ? 1'b1 : (ore_ram ? 1'b0 : s1_vld_q);
    s2_vld_d = ram_ore ? 1'b1 : (pop ? 1'b0 : s2_vld_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q     <= 6'd0;
      rp_q     <= 6'd0;
      uc_q     <= 6'd0;
      cnt_q    <= 6'd0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      uc_q     <= uc_d;
      cnt_q    <= cnt_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule
